// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode widths, opcodes, fetch FSM state type and the NOP encoding
package cpu_pkg;
    localparam int OPW = 4;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0001;
    localparam logic [OPW-1:0] OP_LW   = 4'b1000;
    localparam logic [OPW-1:0] OP_SW   = 4'b1001;
    localparam logic [OPW-1:0] OP_BEQ  = 4'b1100;
    localparam logic [OPW-1:0] OP_JMP  = 4'b1110;
    localparam logic [OPW-1:0] OP_HALT = 4'b1111;
    localparam logic [15:0] INSTR_NOP = 16'h0000;
    typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus.
//   Hazard/redirect inputs: stall, branch_taken/branch_target, jump/jump_target.
//   Instruction memory: imem_addr out, imem_rdata in.
//   IF/ID outputs: instr_out, op, pc_out, pc_plus1_out, valid_out, halted.
//   The master modport is the fetch stage; the slave modport is the environment.
interface fetch_stage_if #(parameter int PC_W = 8, parameter int INSTR_W = 16);
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               jump;
    logic [PC_W-1:0]    jump_target;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr_out;
    logic [3:0]         op;
    logic [PC_W-1:0]    pc_out;
    logic [PC_W-1:0]    pc_plus1_out;
    logic               valid_out;
    logic               halted;
    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
        output imem_addr, instr_out, op, pc_out, pc_plus1_out, valid_out, halted
    );
    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
        input  imem_addr, instr_out, op, pc_out, pc_plus1_out, valid_out, halted
    );
endinterface

// File: rtl/pc_reg.sv
// pc_reg: program counter register.
//   clk, reset   : clock and synchronous active-high reset (PC -> 0)
//   i_redirect   : load i_target (beats hold)
//   i_hold       : keep the current PC
//   o_pc         : current PC; otherwise increments each edge, wrapping at 2^PC_W
module pc_reg #(parameter int PC_W = 8) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_hold,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc
);
    logic [PC_W-1:0] r_pc;
    always_ff @(posedge clk)
        r_pc <= reset ? '0 : i_redirect ? i_target : i_hold ? r_pc : r_pc + PC_W'(1);
    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register, stall, redirect flush and halt.
//   clk, reset : clock and synchronous active-high reset
//   bus        : fetch_stage_if.master (hazard/redirect inputs, imem port, IF/ID outputs)
//   FETCH_HALT_EN: when defined, opcode 4'b1111 parks fetch in HALTED until a redirect
//   or reset; when undefined, halted is 0 and 4'b1111 is fetched like any other opcode.
import cpu_pkg::*;
module fetch_stage #(parameter int PC_W = 8, parameter int INSTR_W = 16) (
    input logic clk,
    input logic reset,
    fetch_stage_if.master bus
);
    logic [PC_W-1:0]    w_pc;
    logic [PC_W-1:0]    w_target;
    logic               w_redirect;
    logic               w_in_halt;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_out;
    logic               r_valid;

    assign w_redirect = bus.jump | bus.branch_taken;
    assign w_target   = bus.jump ? bus.jump_target : bus.branch_target;

    pc_reg #(.PC_W(PC_W)) u_pc (
        .clk        (clk),
        .reset      (reset),
        .i_hold     (bus.stall | w_in_halt),
        .i_redirect (w_redirect),
        .i_target   (w_target),
        .o_pc       (w_pc)
    );

    // A redirect flushes the wrong-path fetch; while halted, each unstalled edge inserts a bubble.
    always_ff @(posedge clk) begin
        if (reset || w_redirect || (!bus.stall && w_in_halt)) begin
            r_instr  <= INSTR_W'(INSTR_NOP);
            r_pc_out <= '0;
            r_valid  <= 1'b0;
        end else if (!bus.stall) begin
            r_instr  <= bus.imem_rdata;
            r_pc_out <= w_pc;
            r_valid  <= 1'b1;
        end
    end

`ifdef FETCH_HALT_EN
    fetch_state_t r_state;
    logic         r_halted;
    // Enter HALTED on the same edge that loads the halt opcode, so halted lines up with op == F.
    always_ff @(posedge clk) begin
        if (reset || w_redirect) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else if (r_state == RUN && !bus.stall && bus.imem_rdata[INSTR_W-1 -: OPW] == OP_HALT) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
        end
    end
    assign w_in_halt  = r_state == HALTED;
    assign bus.halted = r_halted;
`else
    assign w_in_halt  = 1'b0;
    assign bus.halted = 1'b0;
`endif

    assign bus.imem_addr    = w_pc;
    assign bus.instr_out    = r_instr;
    assign bus.op           = r_instr[INSTR_W-1 -: OPW];
    assign bus.pc_out       = r_pc_out;
    assign bus.pc_plus1_out = r_pc_out + PC_W'(1);
    assign bus.valid_out    = r_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] rom [256];

    fetch_stage_if bus();
    fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    assign bus.imem_rdata = rom[bus.imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic br, input logic [7:0] bt,
                         input logic jp, input logic [7:0] jt);
        bus.stall = st;
        bus.branch_taken = br;
        bus.branch_target = bt;
        bus.jump = jp;
        bus.jump_target = jt;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".imem_addr"}, 32'(bus.imem_addr), 0);
        check({tag, ".instr"}, 32'(bus.instr_out), 0);
        check({tag, ".op"}, 32'(bus.op), 0);
        check({tag, ".pc_out"}, 32'(bus.pc_out), 0);
        check({tag, ".pc_plus1"}, 32'(bus.pc_plus1_out), 1);
        check({tag, ".valid"}, 32'(bus.valid_out), 0);
        check({tag, ".halted"}, 32'(bus.halted), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 8'h00, 0, 8'h00);
        step();
        reset = 1'b0;
    endtask

    logic [3:0] exp_op [5] = '{4'h0, 4'h1, 4'h0, 4'hC, 4'hE};
    logic [7:0] exp_pc [5] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
    logic       exp_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h2000 | 16'(i);
        rom[0] = 16'h1000;
        rom[1] = 16'h0123;
        rom[2] = 16'hC456;
        rom[3] = 16'hE789;
        rom[5] = 16'hF000;

        do_reset();
        check_reset_state("reset");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            check($sformatf("run%0d.op", i), 32'(bus.op), 32'(exp_op[i]));
            check($sformatf("run%0d.pc_out", i), 32'(bus.pc_out), 32'(exp_pc[i]));
            check($sformatf("run%0d.valid", i), 32'(bus.valid_out), 32'(exp_v[i]));
        end

        do_reset();
        step();
        step();
        check("pre_stall.instr", 32'(bus.instr_out), 32'h0123);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("stall%0d.instr", i), 32'(bus.instr_out), 32'h0123);
            check($sformatf("stall%0d.pc_out", i), 32'(bus.pc_out), 1);
            check($sformatf("stall%0d.pc", i), 32'(bus.imem_addr), 2);
        end
        bus.stall = 1'b0;
        step();
        check("resume.instr", 32'(bus.instr_out), 32'hC456);
        check("resume.pc_out", 32'(bus.pc_out), 2);
        step();
        check("resume2.instr", 32'(bus.instr_out), 32'hE789);
        check("resume2.pc", 32'(bus.imem_addr), 4);

        drive(1, 1, 8'h20, 0, 8'h00);
        step();
        check("br_stall.valid", 32'(bus.valid_out), 0);
        check("br_stall.instr", 32'(bus.instr_out), 0);
        check("br_stall.pc", 32'(bus.imem_addr), 32'h20);
        drive(0, 0, 8'h00, 0, 8'h00);
        step();
        check("br_tgt.instr", 32'(bus.instr_out), 32'h2020);
        check("br_tgt.pc_out", 32'(bus.pc_out), 32'h20);
        check("br_tgt.valid", 32'(bus.valid_out), 1);

        drive(0, 1, 8'h30, 1, 8'h10);
        step();
        check("jb.valid", 32'(bus.valid_out), 0);
        check("jb.pc", 32'(bus.imem_addr), 32'h10);
        drive(0, 0, 8'h00, 0, 8'h00);
        step();
        check("jb_tgt.instr", 32'(bus.instr_out), 32'h2010);
        check("jb_tgt.pc_out", 32'(bus.pc_out), 32'h10);

        drive(0, 0, 8'h00, 1, 8'h04);
        step();
        drive(0, 0, 8'h00, 0, 8'h00);
        step();
        step();
        check("halt_ld.op", 32'(bus.op), 32'hF);
        check("halt_ld.pc_out", 32'(bus.pc_out), 5);
        check("halt_ld.valid", 32'(bus.valid_out), 1);
        check("halt_ld.pc", 32'(bus.imem_addr), 6);
`ifdef FETCH_HALT_EN
        check("halt_ld.halted", 32'(bus.halted), 1);
        bus.stall = 1'b1;
        step();
        check("halt_stall.valid", 32'(bus.valid_out), 1);
        check("halt_stall.op", 32'(bus.op), 32'hF);
        check("halt_stall.halted", 32'(bus.halted), 1);
        bus.stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("halted%0d.valid", i), 32'(bus.valid_out), 0);
            check($sformatf("halted%0d.halted", i), 32'(bus.halted), 1);
            check($sformatf("halted%0d.pc", i), 32'(bus.imem_addr), 6);
        end
        drive(0, 1, 8'h08, 0, 8'h00);
        step();
        check("unhalt.halted", 32'(bus.halted), 0);
        check("unhalt.valid", 32'(bus.valid_out), 0);
        check("unhalt.pc", 32'(bus.imem_addr), 8);
        drive(0, 0, 8'h00, 0, 8'h00);
        step();
        check("unhalt_tgt.instr", 32'(bus.instr_out), 32'h2008);
        check("unhalt_tgt.pc_out", 32'(bus.pc_out), 8);
        check("unhalt_tgt.valid", 32'(bus.valid_out), 1);
`else
        check("halt_ld.halted", 32'(bus.halted), 0);
        step();
        check("no_halt.instr", 32'(bus.instr_out), 32'h2006);
        check("no_halt.pc_out", 32'(bus.pc_out), 6);
        check("no_halt.valid", 32'(bus.valid_out), 1);
        check("no_halt.pc", 32'(bus.imem_addr), 7);
`endif

        drive(0, 0, 8'h00, 1, 8'hFE);
        step();
        drive(0, 0, 8'h00, 0, 8'h00);
        step();
        check("wrap_fe.instr", 32'(bus.instr_out), 32'h20FE);
        check("wrap_fe.pc_out", 32'(bus.pc_out), 32'hFE);
        step();
        check("wrap_ff.pc_out", 32'(bus.pc_out), 32'hFF);
        check("wrap_ff.pc_plus1", 32'(bus.pc_plus1_out), 0);
        check("wrap_ff.pc", 32'(bus.imem_addr), 0);
        step();
        check("wrap_00.instr", 32'(bus.instr_out), 32'h1000);
        check("wrap_00.pc_out", 32'(bus.pc_out), 0);
        check("wrap_00.pc_plus1", 32'(bus.pc_plus1_out), 1);

        step();
        reset = 1'b1;
        drive(1, 1, 8'h44, 1, 8'h33);
        step();
        check_reset_state("mid_reset");
        reset = 1'b0;
        drive(0, 0, 8'h00, 0, 8'h00);
        step();
        check("post_reset.instr", 32'(bus.instr_out), 32'h1000);
        check("post_reset.valid", 32'(bus.valid_out), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the 4-bit-opcode CPU. Holds the PC, drives the instruction memory read address, and registers the fetched 16-bit instruction. Presents `op = instr[15:12]` directly to the main decoder (`maindec`) in the decode stage. Handles stall, branch/jump redirect with wrong-path flush, and halt.

## Interface

**Parameters**
- `PC_W`, default 8: PC and instruction-memory address width (word-addressed).
- `INSTR_W`, default 16: instruction width; the opcode is always the top 4 bits.

**Ports**
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `stall` input 1: hold PC and the IF/ID register (load-use hazard from decode).
- `branch_taken` input 1: the branch resolved in a later stage is taken.
- `branch_target` input PC_W: branch destination.
- `jump` input 1: the jump resolved in decode.
- `jump_target` input PC_W: jump destination.
- `imem_addr` output PC_W: combinational read address; equals the PC register.
- `imem_rdata` input INSTR_W: instruction at `imem_addr`, valid in the same cycle (asynchronous-read ROM).
- `instr_out` output INSTR_W: registered IF/ID instruction.
- `op` output 4: `instr_out[INSTR_W-1 -: 4]`, feeding `maindec.op`.
- `pc_out` output PC_W: PC of `instr_out`.
- `pc_plus1_out` output PC_W: `pc_out + 1`, mod 2^PC_W.
- `valid_out` output 1: `instr_out` is a real instruction (0 means bubble).
- `halted` output 1: the fetch FSM is in HALTED.

## Operation

- **FSM states:** RUN and HALTED. Reset enters RUN.
- **Next-PC priority in RUN**, highest first:
  1. `reset` → PC = 0.
  2. `jump` → PC = `jump_target`.
  3. `branch_taken` → PC = `branch_target`.
  4. `stall` → PC holds.
  5. Otherwise PC = PC + 1. Wraps from 2^PC_W−1 to 0; no overflow flag.
- **IF/ID register update:**
  - On redirect (`jump` or `branch_taken`): load `instr_out` = 16'h0000, `valid_out` = 0, `pc_out` = 0. This flushes the wrong-path fetch.
  - Else on `stall`: hold all IF/ID fields.
  - Else: load `instr_out` = `imem_rdata`, `pc_out` = PC, `valid_out` = 1.
  - Redirect wins over a simultaneous `stall`.
  - `jump` and `branch_taken` together: `jump_target` wins.
- **Halt:** when RUN loads an instruction with opcode 4'b1111 into IF/ID, the FSM moves to HALTED on the same edge.
  - The halt instruction itself stays valid in IF/ID.
- **In HALTED:**
  - PC holds.
  - The next non-stalled edge loads a bubble (`valid_out` = 0).
  - `stall` still holds IF/ID.
- **Leaving HALTED:**
  - A redirect (from an older instruction, so the halt was wrong-path) applies the normal redirect update and returns the FSM to RUN.
  - Only `reset` or a redirect leaves HALTED.

## Timing

- **Reset values** (cycle after `reset` sampled high):
  - PC = 0, `imem_addr` = 0.
  - `instr_out` = 0, `op` = 0, `pc_out` = 0, `pc_plus1_out` = 1.
  - `valid_out` = 0, `halted` = 0.
- **Reset mid-operation:** overrides stall, redirect and HALTED in the same edge.
- **Latency:** instruction at address A appears on `instr_out`/`op` one edge after PC = A (1-cycle fetch latency).
- **Redirect penalty:** one bubble. Target instruction is on `instr_out` two edges after the redirect is sampled.
- **Back-to-back redirects:** each is honoured on its own edge; the later one wins.
- `halted` asserts in the same cycle that the halt opcode appears on `op`.
- All outputs except `imem_addr`, `op` and `pc_plus1_out` are registers. Those three are combinational from registers only, with no path from any input.

## Configuration

- **Macro:** `FETCH_HALT_EN`.
- **Defined:** opcode 4'b1111 triggers HALTED as described above.
- **Undefined:**
  - No FSM; `halted` is tied to 0.
  - 4'b1111 is fetched like any other opcode and the PC keeps incrementing.

## Structure

- **Shared package `cpu_pkg`:**
  - `OPW` = 4.
  - Opcode localparams, including `OP_HALT` = 4'b1111.
  - `fetch_state_t` enum {RUN, HALTED}.
  - Default NOP `INSTR_NOP` = 16'h0000.
- **Sub-module `pc_reg`:** PC register with reset, hold, redirect mux and increment. Parameterised by `PC_W`.
- The IF/ID register and FSM live in `fetch_stage`.

## Test plan

- **Reset then free-run:** ROM[0..3] = 16'h1000, 16'h0123, 16'hC456, 16'hE789.
  - `op` sequence after reset is 0,1,0,C,E.
  - `pc_out` = 0,0,1,2,3; `valid_out` = 0,1,1,1,1.
- **Stall:** `stall` held 2 cycles while `instr_out` = 16'h0123.
  - `instr_out`, `pc_out` and PC frozen.
  - Sequence resumes with 16'hC456 and no instruction is skipped.
- **Branch during stall:** `branch_taken` = 1 with `branch_target` = 8'h20, `stall` = 1 in the same cycle.
  - Next `valid_out` = 0.
  - The following `instr_out` = ROM[0x20] with `pc_out` = 8'h20.
- **Jump + branch together:** `jump_target` = 8'h10, `branch_target` = 8'h30.
  - The fetch resumes at 8'h10.
- **Halt (`FETCH_HALT_EN`):** ROM[5] = 16'hF000.
  - `halted` = 1 when `op` = F; the next cycle is a bubble and PC stays 6.
  - A later `branch_taken` to 8'h08 clears `halted` and fetches ROM[8].
- **Wrap and reset:**
  - PC at 8'hFF wraps to 8'h00 with `pc_plus1_out` = 0 for `pc_out` = 8'hFF.
  - `reset` asserted mid-run returns all outputs to their reset values in one edge.
